pingpong_shift_ctrl: RTL and testbench

//  Issuing side of the bank-swap interface: produces one-cycle chng_wrt_shft / chng_rd_shft pulses.
//  The toggle-based bank selector consumes these pulses.

---
 rtl/pingpong_shift_ctrl_pkg.sv | 20 ++
 rtl/pingpong_bank_ptr.sv | 59 +++++
 rtl/pingpong_shift_ctrl.sv | 108 ++++++++++
 tb/tb_pingpong_shift_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_shift_ctrl_pkg.sv
// Shared definitions for the ping-pong bank controller: bank count,
// default address width and the two-state pointer FSM encodings.
package pingpong_shift_ctrl_pkg;

    localparam int NUM_BANKS  = 2;
    localparam int DEFAULT_AW = 8;

    // Both pointers run the same two-state machine; the write and read
    // names below are aliases so each side reads in its own terms.
    typedef enum logic {
        PTR_RUN  = 1'b0,
        PTR_SWAP = 1'b1
    } ptr_state_t;

    localparam ptr_state_t W_FILL  = PTR_RUN;
    localparam ptr_state_t W_SWAP  = PTR_SWAP;
    localparam ptr_state_t R_DRAIN = PTR_RUN;
    localparam ptr_state_t R_SWAP  = PTR_SWAP;

endpackage

// File: rtl/pingpong_bank_ptr.sv
// One side (writer or reader) of the ping-pong sequencer: in-bank address
// counter, mirror of the selector's bank bit, and the one-cycle swap pulse.
// The caller decides when a bank closes; this block only sequences it.
module pingpong_bank_ptr
    import pingpong_shift_ctrl_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          advance,   // a word was granted this cycle
    input  logic          close,     // the granted word ends the bank
    output logic [AW-1:0] addr,
    output logic          bank,
    output logic          shft,
    output ptr_state_t    state
);

    logic [AW-1:0] addr_reg;
    logic          bank_reg;
    logic          shft_reg;
    ptr_state_t    state_reg;

    // Address/bank sequencing; the pulse is high exactly while in PTR_SWAP,
    // and the mirror bit flips as that cycle ends, matching the selector.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_reg  <= '0;
            bank_reg  <= 1'b0;
            shft_reg  <= 1'b0;
            state_reg <= PTR_RUN;
        end else begin
            case (state_reg)
                PTR_RUN: begin
                    if (advance) begin
                        if (close) begin
                            addr_reg  <= '0;
                            shft_reg  <= 1'b1;
                            state_reg <= PTR_SWAP;
                        end else begin
                            addr_reg <= addr_reg + AW'(1);
                        end
                    end
                end
                PTR_SWAP: begin
                    shft_reg  <= 1'b0;
                    bank_reg  <= ~bank_reg;
                    state_reg <= PTR_RUN;
                end
            endcase
        end
    end

    assign addr  = addr_reg;
    assign bank  = bank_reg;
    assign shft  = shft_reg;
    assign state = state_reg;

endmodule

// File: rtl/pingpong_shift_ctrl.sv
// Issuing side of the ping-pong bank-swap interface. Grants writes into the
// current write bank and reads from the current read bank, tracks which
// banks hold unread data and how long each fill was, and emits one-cycle
// swap pulses to the toggle-based bank selector.
module pingpong_shift_ctrl
    import pingpong_shift_ctrl_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_req,
    input  logic                 wr_last,
    output logic                 wr_grant,
    output logic [AW-1:0]        wr_addr,
    input  logic                 rd_req,
    output logic                 rd_grant,
    output logic [AW-1:0]        rd_addr,
    output logic                 rd_last,
    output logic                 chng_wrt_shft,
    output logic                 chng_rd_shft,
    output logic                 wrt_bank,
    output logic                 rd_bank,
    output logic [NUM_BANKS-1:0] bank_full,
    output logic                 overflow
);

    ptr_state_t w_state;
    ptr_state_t r_state;
    logic       wr_close;
    logic       wr_in_fill;
    logic       rd_in_drain;
    logic       release_block;
    logic       overflow_reg;
    logic [AW:0] len_arr [NUM_BANKS];
    logic [AW:0] rd_len_m1;

    assign wr_in_fill  = (w_state == W_FILL);
    assign rd_in_drain = (r_state == R_DRAIN);

    // A bank freed by the reader only becomes writable once the read-swap
    // cycle has completed, so the selector has moved off it first.
    assign release_block = (r_state == R_SWAP) && (rd_bank == wrt_bank);

    assign wr_grant = wr_req && wr_in_fill && !bank_full[wrt_bank] && !release_block;
    assign wr_close = wr_grant && (wr_last || (wr_addr == {AW{1'b1}}));

    assign rd_grant  = rd_req && rd_in_drain && bank_full[rd_bank];
    assign rd_len_m1 = len_arr[rd_bank] - (AW+1)'(1);
    assign rd_last   = rd_grant && ({1'b0, rd_addr} == rd_len_m1);

    pingpong_bank_ptr #(.AW(AW)) u_wr_ptr (
        .clock   (clock),
        .reset   (reset),
        .advance (wr_grant),
        .close   (wr_close),
        .addr    (wr_addr),
        .bank    (wrt_bank),
        .shft    (chng_wrt_shft),
        .state   (w_state)
    );

    pingpong_bank_ptr #(.AW(AW)) u_rd_ptr (
        .clock   (clock),
        .reset   (reset),
        .advance (rd_grant),
        .close   (rd_last),
        .addr    (rd_addr),
        .bank    (rd_bank),
        .shft    (chng_rd_shft),
        .state   (r_state)
    );

    // Per-bank full flag and stored fill length. A set and a clear in the
    // same cycle always land on different banks, so each bank sees at most one.
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic        full_reg;
        logic [AW:0] len_reg;

        // Writer closing this bank marks it full; reader finishing it frees it.
        always_ff @(posedge clock) begin
            if (reset) begin
                full_reg <= 1'b0;
                len_reg  <= '0;
            end else if (wr_close && (wrt_bank == 1'(gi))) begin
                full_reg <= 1'b1;
                len_reg  <= {1'b0, wr_addr} + (AW+1)'(1);
            end else if (rd_last && (rd_bank == 1'(gi))) begin
                full_reg <= 1'b0;
            end
        end

        assign bank_full[gi] = full_reg;
        assign len_arr[gi]   = len_reg;
    end

    // Sticky overflow: a fill-state write refused because its bank is full.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (wr_req && wr_in_fill && bank_full[wrt_bank]) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;

endmodule

// File: tb/tb_pingpong_shift_ctrl.sv
// Directed bench for pingpong_shift_ctrl at AW=2 (four-word banks).
module tb_pingpong_shift_ctrl;

    localparam int AW = 2;

    logic          clock;
    logic          reset;
    logic          wr_req;
    logic          wr_last;
    logic          wr_grant;
    logic [AW-1:0] wr_addr;
    logic          rd_req;
    logic          rd_grant;
    logic [AW-1:0] rd_addr;
    logic          rd_last;
    logic          chng_wrt_shft;
    logic          chng_rd_shft;
    logic          wrt_bank;
    logic          rd_bank;
    logic [1:0]    bank_full;
    logic          overflow;

    int total;
    int bad;

    pingpong_shift_ctrl #(.AW(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .wr_req        (wr_req),
        .wr_last       (wr_last),
        .wr_grant      (wr_grant),
        .wr_addr       (wr_addr),
        .rd_req        (rd_req),
        .rd_grant      (rd_grant),
        .rd_addr       (rd_addr),
        .rd_last       (rd_last),
        .chng_wrt_shft (chng_wrt_shft),
        .chng_rd_shft  (chng_rd_shft),
        .wrt_bank      (wrt_bank),
        .rd_bank       (rd_bank),
        .bank_full     (bank_full),
        .overflow      (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then settle before checks.
    task automatic next_cycle(input logic r, input logic wq, input logic wl, input logic rq);
        @(negedge clock);
        reset   = r;
        wr_req  = wq;
        wr_last = wl;
        rd_req  = rq;
        #1;
        $display("t=%0t rst=%0b wq=%0b wl=%0b rq=%0b | wg=%0b wa=%0d rg=%0b ra=%0d rl=%0b ws=%0b rs=%0b wb=%0b rb=%0b full=%b ovf=%0b",
                 $time, r, wq, wl, rq, wr_grant, wr_addr, rd_grant, rd_addr, rd_last,
                 chng_wrt_shft, chng_rd_shft, wrt_bank, rd_bank, bank_full, overflow);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_addr"},  8'(wr_addr),      8'd0);
        chk({tag, "_rd_addr"},  8'(rd_addr),      8'd0);
        chk({tag, "_wrt_bank"}, 8'(wrt_bank),     8'd0);
        chk({tag, "_rd_bank"},  8'(rd_bank),      8'd0);
        chk({tag, "_full"},     8'(bank_full),    8'd0);
        chk({tag, "_wshft"},    8'(chng_wrt_shft), 8'd0);
        chk({tag, "_rshft"},    8'(chng_rd_shft), 8'd0);
        chk({tag, "_ovf"},      8'(overflow),     8'd0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        wr_req  = 1'b0;
        wr_last = 1'b0;
        rd_req  = 1'b0;

        // Reset state
        next_cycle(1, 0, 0, 0);
        next_cycle(0, 0, 0, 0);
        chk_all_zero("rst");
        chk("rst_wr_grant", 8'(wr_grant), 8'd0);
        chk("rst_rd_grant", 8'(rd_grant), 8'd0);

        // 1: four writes fill bank 0 by address wrap
        for (int i = 0; i < 4; i++) begin
            next_cycle(0, 1, 0, 0);
            chk("t1_wr_grant", 8'(wr_grant), 8'd1);
            chk("t1_wr_addr",  8'(wr_addr),  8'(i));
        end
        next_cycle(0, 0, 0, 0);
        chk("t1_wshft_hi",  8'(chng_wrt_shft), 8'd1);
        chk("t1_full",      8'(bank_full),     8'b01);
        chk("t1_wbank_old", 8'(wrt_bank),      8'd0);
        chk("t1_addr_rst",  8'(wr_addr),       8'd0);
        next_cycle(0, 0, 0, 0);
        chk("t1_wshft_lo",  8'(chng_wrt_shft), 8'd0);
        chk("t1_wbank_new", 8'(wrt_bank),      8'd1);

        // 2: drain bank 0, rd_last only on the fourth word
        for (int i = 0; i < 4; i++) begin
            next_cycle(0, 0, 0, 1);
            chk("t2_rd_grant", 8'(rd_grant), 8'd1);
            chk("t2_rd_addr",  8'(rd_addr),  8'(i));
            chk("t2_rd_last",  8'(rd_last),  (i == 3) ? 8'd1 : 8'd0);
        end
        next_cycle(0, 0, 0, 0);
        chk("t2_rshft_hi", 8'(chng_rd_shft), 8'd1);
        chk("t2_full",     8'(bank_full),    8'b00);
        chk("t2_rbank_old", 8'(rd_bank),     8'd0);
        next_cycle(0, 0, 0, 0);
        chk("t2_rshft_lo",  8'(chng_rd_shft), 8'd0);
        chk("t2_rbank_new", 8'(rd_bank),      8'd1);

        // 3: hold wr_req through both fills; swap cycles stall without overflow
        for (int i = 0; i < 10; i++) begin
            next_cycle(0, 1, 0, 0);
            chk("t3_wr_grant", 8'(wr_grant), (i == 4 || i == 9) ? 8'd0 : 8'd1);
            if (i != 4 && i != 9)
                chk("t3_wr_addr", 8'(wr_addr), (i < 4) ? 8'(i) : 8'(i - 5));
            else
                chk("t3_wshft", 8'(chng_wrt_shft), 8'd1);
            chk("t3_ovf_clear", 8'(overflow), 8'd0);
        end
        next_cycle(0, 1, 0, 0);
        chk("t3_both_full", 8'(bank_full), 8'b11);
        chk("t3_refused",   8'(wr_grant),  8'd0);
        chk("t3_wbank",     8'(wrt_bank),  8'd1);
        chk("t3_ovf_pre",   8'(overflow),  8'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle(0, 1, 0, 1);
            chk("t3_ovf_set",  8'(overflow), 8'd1);
            chk("t3_wr_stall", 8'(wr_grant), 8'd0);
            chk("t3_rd_grant", 8'(rd_grant), 8'd1);
            chk("t3_rd_addr",  8'(rd_addr),  8'(i));
            chk("t3_rd_last",  8'(rd_last),  (i == 3) ? 8'd1 : 8'd0);
        end
        next_cycle(0, 1, 0, 0);
        chk("t3_rshft",       8'(chng_rd_shft), 8'd1);
        chk("t3_full_freed",  8'(bank_full),    8'b01);
        chk("t3_no_wr_rswap", 8'(wr_grant),     8'd0);
        next_cycle(0, 1, 0, 0);
        chk("t3_rbank",     8'(rd_bank),  8'd0);
        chk("t3_wr_resume", 8'(wr_grant), 8'd1);
        chk("t3_wr_addr0",  8'(wr_addr),  8'd0);

        // 6: reset mid-fill with overflow set and a close in flight
        next_cycle(0, 1, 0, 0);
        chk("t6_wr_addr1", 8'(wr_addr), 8'd1);
        next_cycle(1, 1, 1, 0);
        chk("t6_pre_addr", 8'(wr_addr),   8'd2);
        chk("t6_pre_full", 8'(bank_full), 8'b01);
        chk("t6_pre_ovf",  8'(overflow),  8'd1);
        next_cycle(0, 0, 0, 0);
        chk_all_zero("t6");

        // 4 + 5: wr_last on second word gives len 2; then a write close on
        // bank 1 coincides with the read close on bank 0
        next_cycle(0, 1, 0, 0);
        chk("t4_wr_addr0", 8'(wr_addr), 8'd0);
        next_cycle(0, 1, 1, 0);
        chk("t4_wr_grant1", 8'(wr_grant), 8'd1);
        chk("t4_wr_addr1",  8'(wr_addr),  8'd1);
        next_cycle(0, 0, 0, 0);
        chk("t4_wshft", 8'(chng_wrt_shft), 8'd1);
        chk("t4_full",  8'(bank_full),     8'b01);
        next_cycle(0, 1, 0, 1);
        chk("t5_wbank",     8'(wrt_bank), 8'd1);
        chk("t5_wr_addr0",  8'(wr_addr),  8'd0);
        chk("t4_rd_grant0", 8'(rd_grant), 8'd1);
        chk("t4_rd_addr0",  8'(rd_addr),  8'd0);
        chk("t4_rd_last0",  8'(rd_last),  8'd0);
        next_cycle(0, 1, 1, 1);
        chk("t5_wr_grant1", 8'(wr_grant), 8'd1);
        chk("t4_rd_addr1",  8'(rd_addr),  8'd1);
        chk("t4_rd_last1",  8'(rd_last),  8'd1);
        chk("t5_full_pre",  8'(bank_full), 8'b01);
        next_cycle(0, 0, 0, 0);
        chk("t5_wshft",     8'(chng_wrt_shft), 8'd1);
        chk("t5_rshft",     8'(chng_rd_shft),  8'd1);
        chk("t5_full_post", 8'(bank_full),     8'b10);
        next_cycle(0, 0, 0, 0);
        chk("t5_wshft_lo", 8'(chng_wrt_shft), 8'd0);
        chk("t5_rshft_lo", 8'(chng_rd_shft),  8'd0);
        chk("t5_wbank",    8'(wrt_bank),      8'd0);
        chk("t5_rbank",    8'(rd_bank),       8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
